// File: rtl/boot_pkg.sv
// Shared definitions for the Hack program-load controller: FSM states,
// frame field widths and image capacity derivation.
package boot_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;

    typedef enum logic [3:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DAT_HI,
        S_DAT_LO,
        S_WRITE,
        S_SUM_HI,
        S_SUM_LO,
        S_CHECK,
        S_RELEASE,
        S_RUN,
        S_ERR
    } boot_state_e;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/boot_word_asm.sv
// Big-endian byte-pair assembler shared by the count, data and checksum fields.
module boot_word_asm
    import boot_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_hi_en,
    input  logic              i_lo_en,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [WORD_W-1:0] o_word_now,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_done
);

    logic [BYTE_W-1:0] r_hi;
    logic [WORD_W-1:0] r_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi   <= '0;
            r_word <= '0;
        end else if (i_clr) begin
            r_hi   <= '0;
        end else begin
            if (i_hi_en) begin
                r_hi <= i_byte;
            end
            if (i_lo_en) begin
                r_word <= {r_hi, i_byte};
            end
        end
    end

    // o_word_now lets the FSM decide on the count in the same cycle the lo byte lands.
    assign o_word_now  = {r_hi, i_byte};
    assign o_word      = r_word;
    assign o_word_done = i_lo_en;

endmodule

// File: rtl/boot_loader.sv
// Program-load controller: streams a COUNT/data/CHECKSUM frame into the
// instruction ROM and holds the CPU in reset until the image verifies.
module boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              boot_req,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              rx_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [WORD_W-1:0] rom_data,
    output logic              cpu_reset,
    output logic              busy,
    output logic              error
);

    localparam int unsigned     DEPTH   = depth_of(ADDR_W);
    localparam logic [WORD_W:0] DEPTH_V = DEPTH[WORD_W:0];

    boot_state_e       r_state;
    boot_state_e       w_next;
    logic              w_rx_ready;
    logic              w_accept;
    logic              w_hi_en;
    logic              w_lo_en;
    logic [WORD_W-1:0] w_word_now;
    logic [WORD_W-1:0] w_word_q;
    logic              w_word_done;

    logic [ADDR_W-1:0] r_index;
    logic [WORD_W-1:0] r_remain;
    logic [WORD_W-1:0] r_sum;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [WORD_W-1:0] r_rom_data;

    assign w_rx_ready = !boot_req &&
                        (r_state inside {S_CNT_HI, S_CNT_LO, S_DAT_HI,
                                         S_DAT_LO, S_SUM_HI, S_SUM_LO});
    assign w_accept   = rx_valid && w_rx_ready;
    assign w_hi_en    = w_accept && (r_state inside {S_CNT_HI, S_DAT_HI, S_SUM_HI});
    assign w_lo_en    = w_accept && (r_state inside {S_CNT_LO, S_DAT_LO, S_SUM_LO});

    boot_word_asm u_word_asm (
        .clk         (clk),
        .rst_n       (reset),
        .i_clr       (boot_req),
        .i_hi_en     (w_hi_en),
        .i_lo_en     (w_lo_en),
        .i_byte      (rx_data),
        .o_word_now  (w_word_now),
        .o_word      (w_word_q),
        .o_word_done (w_word_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_CNT_HI;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CNT_HI: begin
                if (w_hi_en) w_next = S_CNT_LO;
            end
            S_CNT_LO: begin
                if (w_word_done) begin
                    if ({1'b0, w_word_now} > DEPTH_V) begin
                        w_next = S_ERR;
                    end else if (w_word_now == '0) begin
                        w_next = S_SUM_HI;
                    end else begin
                        w_next = S_DAT_HI;
                    end
                end
            end
            S_DAT_HI: begin
                if (w_hi_en) w_next = S_DAT_LO;
            end
            S_DAT_LO: begin
                if (w_word_done) w_next = S_WRITE;
            end
            S_WRITE: begin
                w_next = (r_remain != WORD_W'(1)) ? S_DAT_HI : S_SUM_HI;
            end
            S_SUM_HI: begin
                if (w_hi_en) w_next = S_SUM_LO;
            end
            S_SUM_LO: begin
                if (w_word_done) w_next = S_CHECK;
            end
            S_CHECK: begin
                w_next = (w_word_q == r_sum) ? S_RELEASE : S_ERR;
            end
            S_RELEASE: begin
                w_next = S_RUN;
            end
            S_RUN: begin
                w_next = S_RUN;
            end
            S_ERR: begin
                w_next = S_ERR;
            end
            default: begin
                w_next = S_ERR;
            end
        endcase
        if (boot_req) begin
            w_next = S_CNT_HI;
        end
    end

    // Index stops at the last word so a full DEPTH image never wraps to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_index    <= '0;
            r_remain   <= '0;
            r_sum      <= '0;
            r_rom_addr <= '0;
            r_rom_data <= '0;
        end else if (boot_req) begin
            r_index  <= '0;
            r_remain <= '0;
            r_sum    <= '0;
        end else begin
            if (r_state == S_CNT_LO && w_word_done) begin
                r_remain <= w_word_now;
            end
            if (r_state == S_DAT_LO && w_word_done) begin
                r_rom_addr <= r_index;
                r_rom_data <= w_word_now;
            end
            if (r_state == S_WRITE) begin
                r_sum    <= r_sum + r_rom_data;
                r_remain <= r_remain - 1'b1;
                if (r_remain != WORD_W'(1)) begin
                    r_index <= r_index + 1'b1;
                end
            end
        end
    end

    assign rx_ready  = w_rx_ready;
    assign rom_we    = (r_state == S_WRITE);
    assign rom_addr  = r_rom_addr;
    assign rom_data  = r_rom_data;
    assign cpu_reset = (r_state != S_RUN);
    assign busy      = (r_state != S_RUN) && (r_state != S_ERR);
    assign error     = (r_state == S_ERR);

endmodule
